l2_controller: RTL

L2_CONTROLLER -- requirements
Module: l2_controller

---
 rtl/l2_pkg.sv | 23 ++
 rtl/l2_tag_array.sv | 57 +++++
 rtl/l2_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared types and sizing for the direct-mapped L2 tag controller.
package l2_pkg;

  localparam int TAG_W = 18;
  localparam int IDX_W = 8;
  localparam int LINES = 256;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_WRITE_BACK = 3'd2,
    S_ALLOCATE   = 3'd3,
    S_RESPOND    = 3'd4,
    S_HOLD       = 3'd5
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic             write;
  } req_t;

endpackage

// File: rtl/l2_tag_array.sv
// TAG/valid/dirty storage: combinational read, single synchronous write at the
// same index, whole-array flush of the status bits.
module l2_tag_array
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic [IDX_W-1:0] index,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             set_dirty,
  input  logic             flush
);

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;

  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

  // NOTE: every variable gets a default before the branches, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (flush) begin
      valid_d = '0;
      dirty_d = '0;
    end else if (alloc_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end else if (set_dirty) begin
      dirty_d[index] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: the tag RAM is deliberately not reset; valid=0 already forces a miss.
  always_ff @(posedge clk) begin
    if (alloc_en) tag_mem[index] <= alloc_tag;
  end

endmodule

// File: rtl/l2_controller.sv
// Direct-mapped L2 controller FSM: hit/miss decision, victim write-back,
// line allocation and L1 handshake.
module l2_controller
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic [TAG_W-1:0] tag,
  input  logic [IDX_W-1:0] index,
  input  logic             read_L1_L2,
  input  logic             write_L1_L2,
  input  logic             flush,
  input  logic             ready_MEM_L2,
  output logic             ready_L2_L1,
  output logic             read_L2_MEM,
  output logic             write_L2_MEM,
  output logic             refill_L2,
  output logic             update_L2,
  output logic             stall_L2
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   refill_q, refill_d;

  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid, rd_dirty;
  logic             hit, alloc_en, set_dirty, flush_en;

  l2_tag_array u_tag_array (
    .clk       (clk),
    .nrst      (nrst),
    .index     (req_q.index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .alloc_en  (alloc_en),
    .alloc_tag (req_q.tag),
    .set_dirty (set_dirty),
    .flush     (flush_en)
  );

  assign hit = rd_valid && (rd_tag == req_q.tag);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    refill_d  = 1'b0;
    alloc_en  = 1'b0;
    set_dirty = 1'b0;
    flush_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Flush wins; a simultaneous request stays asserted and is taken next cycle.
        if (flush) begin
          flush_en = 1'b1;
        end else if (write_L1_L2 || read_L1_L2) begin
          req_d.tag   = tag;
          req_d.index = index;
          req_d.write = write_L1_L2;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit)           state_d = S_RESPOND;
        else if (rd_dirty) state_d = S_WRITE_BACK;
        else               state_d = S_ALLOCATE;
      end
      S_WRITE_BACK: begin
        if (ready_MEM_L2) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (ready_MEM_L2) begin
          alloc_en = 1'b1;
          refill_d = 1'b1;
          state_d  = S_COMPARE;
        end
      end
      S_RESPOND: begin
        set_dirty = req_q.write;
        state_d   = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      refill_q <= refill_d;
    end
  end

  assign ready_L2_L1  = (state_q == S_RESPOND);
  assign update_L2    = (state_q == S_RESPOND) && req_q.write;
  assign read_L2_MEM  = (state_q == S_ALLOCATE);
  assign write_L2_MEM = (state_q == S_WRITE_BACK);
  assign stall_L2     = (state_q != S_IDLE);
  assign refill_L2    = refill_q;

endmodule
